// File: rtl/sa_tile_feeder.sv
// sa_tile_feeder
// Streams an X tile (ROWS x K) and a W tile (K x COLS) into the systolic array edges,
// one K-slice per accepted I_PE_SHIFT. The inner length K_LEN is set at run time.
// Lanes can be skewed so that row i / column j lags by i / j steps, and K can be walked
// either forwards or backwards.
//
// Ports:
//   I_CLK, I_ASYN_RSTN   clock, asynchronous active-low reset
//   I_SYNC_RSTN          synchronous active-low reset
//   I_START, I_K_LEN     tile start request and its inner dimension (sampled on start)
//   I_PE_SHIFT           advance one step while feeding
//   I_X_MATRIX           X tile, [row][k]
//   I_W_MATRIX           W tile, [k][col]
//   O_X_VECTOR           element fed into each array row
//   O_W_VECTOR           element fed into each array column
//   O_VALID / O_BUSY     feeding / feeding-or-done
//   O_OVER               tile fully fed (level, held in DONE)
//   O_ERR                one-cycle pulse after a start with an illegal length
module sa_tile_feeder #(
    parameter int unsigned D_W     = 8,
    parameter int unsigned ROWS    = 16,
    parameter int unsigned COLS    = 16,
    parameter int unsigned K_MAX   = 64,
    parameter bit          SKEW_EN = 1'b1,
    parameter bit          REVERSE = 1'b1
) (
    input  logic                                   I_CLK,
    input  logic                                   I_ASYN_RSTN,
    input  logic                                   I_SYNC_RSTN,
    input  logic                                   I_START,
    input  logic                                   I_PE_SHIFT,
    input  logic [$clog2(K_MAX+1)-1:0]             I_K_LEN,
    input  logic [ROWS-1:0][K_MAX-1:0][D_W-1:0]    I_X_MATRIX,
    input  logic [K_MAX-1:0][COLS-1:0][D_W-1:0]    I_W_MATRIX,
    output logic [ROWS-1:0][D_W-1:0]               O_X_VECTOR,
    output logic [COLS-1:0][D_W-1:0]               O_W_VECTOR,
    output logic                                   O_VALID,
    output logic                                   O_BUSY,
    output logic                                   O_OVER,
    output logic                                   O_ERR
);

    localparam int unsigned MAXRC = (ROWS > COLS) ? ROWS : COLS;
    localparam int unsigned TW    = $clog2(K_MAX + MAXRC + 1);
    localparam int unsigned KW    = $clog2(K_MAX + 1);
    localparam int unsigned KW1   = KW + 1;
    localparam int unsigned SW    = (K_MAX > 1) ? $clog2(K_MAX) : 1;

    // Extra steps needed to drain the most-delayed lane when skewing.
    localparam logic [TW-1:0]  SKEW_OFF = SKEW_EN ? TW'(MAXRC - 1) : '0;
    localparam logic [KW1-1:0] KMAX_V   = KW1'(K_MAX);

    typedef enum logic [1:0] {StIdle, StFeed, StDone} state_e;

    state_e          state_q, state_d;
    logic [TW-1:0]   t_q, t_d;
    logic [KW-1:0]   k_len_q, k_len_d;
    logic            err_q, err_d;
    logic [TW-1:0]   t_last;
    logic            len_ok;

    assign t_last = TW'(k_len_q) - TW'(1) + SKEW_OFF;
    assign len_ok = (I_K_LEN != '0) && ({1'b0, I_K_LEN} <= KMAX_V);

    // Source K index for one lane at step t: {in_range, index}. Out-of-range lanes are
    // the skew fill/drain slots and carry no data.
    function automatic logic [SW:0] lane_src(input logic [TW-1:0] t, input int lane,
                                             input logic [KW-1:0] klen);
        int kk;
        kk = int'(t) - (SKEW_EN ? lane : 0);
        if (kk >= 0 && kk < int'(klen)) begin
            if (REVERSE) kk = int'(klen) - 1 - kk;
            return {1'b1, SW'(kk)};
        end
        return '0;
    endfunction

    always_ff @(posedge I_CLK or negedge I_ASYN_RSTN) begin
        if (!I_ASYN_RSTN) begin
            state_q <= StIdle;
            t_q     <= '0;
            k_len_q <= '0;
            err_q   <= 1'b0;
        end else if (!I_SYNC_RSTN) begin
            state_q <= StIdle;
            t_q     <= '0;
            k_len_q <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            t_q     <= t_d;
            k_len_q <= k_len_d;
            err_q   <= err_d;
        end
    end

    always_comb begin
        state_d = state_q;
        t_d     = t_q;
        k_len_d = k_len_q;
        err_d   = 1'b0;
        unique case (state_q)
            // DONE accepts a new start directly so back-to-back tiles need no idle cycle.
            StIdle, StDone: begin
                if (I_START) begin
                    if (len_ok) begin
                        state_d = StFeed;
                        k_len_d = I_K_LEN;
                        t_d     = '0;
                    end else begin
                        err_d = 1'b1;
                    end
                end
            end
            StFeed: begin
                if (I_PE_SHIFT) begin
                    if (t_q == t_last) begin
                        state_d = StDone;
                    end else begin
                        t_d = t_q + TW'(1);
                    end
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_comb begin
        logic [SW:0] sel;
        sel        = '0;
        O_X_VECTOR = '0;
        O_W_VECTOR = '0;
        if (state_q == StFeed) begin
            for (int i = 0; i < ROWS; i++) begin
                sel = lane_src(t_q, i, k_len_q);
                if (sel[SW]) O_X_VECTOR[i] = I_X_MATRIX[i][sel[SW-1:0]];
            end
            for (int j = 0; j < COLS; j++) begin
                sel = lane_src(t_q, j, k_len_q);
                if (sel[SW]) O_W_VECTOR[j] = I_W_MATRIX[sel[SW-1:0]][j];
            end
        end
    end

    assign O_VALID = (state_q == StFeed);
    assign O_BUSY  = (state_q == StFeed) || (state_q == StDone);
    assign O_OVER  = (state_q == StDone);
    assign O_ERR   = err_q;

endmodule
